// File: rtl/down_counter_mod5.sv
// -----------------------------------------------------------------------------
// down_counter_mod5
//
// Prescaled modulo-N down counter. A free-running prescaler divides the board
// clock into a one-clk `tick` every DIV_COUNT cycles. On each tick with `en`
// high, the count `q` steps down MODULUS-1, ..., 1, 0, then wraps back to
// MODULUS-1. A one-clk `borrow` pulse marks the wrap.
//
// Parameters:
//   MODULUS    count range 0..MODULUS-1 (legal 2..8)
//   DIV_COUNT  clk cycles per count tick (legal >= 1)
//
// Ports:
//   clk       in   board clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   en        in   count enable, only looked at on tick cycles
//   load      in   synchronous parallel load strobe; also restarts prescaler
//   load_val  in   [2:0] value to load, clamped to MODULUS-1
//   q         out  [2:0] current count
//   tick      out  one-clk pulse per prescaler period
//   borrow    out  one-clk pulse in the first cycle q shows MODULUS-1 after a wrap
//   zero      out  high while q == 0
//   seg       out  [6:0] active-high segments {g,f,e,d,c,b,a} of q
//                  (only when DOWN_CNT_SEVENSEG_EN is defined)
//
// Configuration macro: DOWN_CNT_SEVENSEG_EN adds the registered seven-segment
// decode of q on port `seg`. Without it there is no `seg` port and no decoder.
// -----------------------------------------------------------------------------
module down_counter_mod5 #(
  parameter int MODULUS   = 5,
  parameter int DIV_COUNT = 27000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] q,
  output logic       tick,
  output logic       borrow,
`ifdef DOWN_CNT_SEVENSEG_EN
  output logic [6:0] seg,
`endif
  output logic       zero
);

  // A single-valued prescaler (DIV_COUNT=1) still gets one bit so the
  // register is never zero-width; it simply stays at 0 and tick stays high.
  localparam int PRE_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_COUNT - 1);
  localparam logic [2:0]       Q_MAX    = 3'(MODULUS - 1);

  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_q;
  logic             r_borrow;

  logic             w_tick;
  logic [PRE_W-1:0] w_pre_next;
  logic [2:0]       w_q_next;
  logic             w_borrow_next;
  logic [2:0]       w_load_clamped;

  assign w_tick         = (r_pre == PRE_LAST);
  assign w_load_clamped = (load_val > Q_MAX) ? Q_MAX : load_val;

  // Next-state logic. Load beats tick/en; a decrement coinciding with a
  // load is discarded, and the load also restarts the prescaler period.
  always_comb begin
    w_pre_next    = r_pre;
    w_q_next      = r_q;
    w_borrow_next = 1'b0;

    if (load) begin
      w_pre_next = '0;
    end else if (w_tick) begin
      w_pre_next = '0;
    end else begin
      w_pre_next = r_pre + PRE_W'(1);
    end

    if (load) begin
      w_q_next = w_load_clamped;
    end else if (w_tick && en) begin
      if (r_q == 3'd0) begin
        w_q_next      = Q_MAX;
        w_borrow_next = 1'b1;
      end else begin
        w_q_next = r_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_q      <= Q_MAX;
      r_borrow <= 1'b0;
    end else begin
      r_pre    <= w_pre_next;
      r_q      <= w_q_next;
      r_borrow <= w_borrow_next;
    end
  end

`ifdef DOWN_CNT_SEVENSEG_EN
  // Segment bits {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      3'd0: s = 7'h3F;
      3'd1: s = 7'h06;
      3'd2: s = 7'h5B;
      3'd3: s = 7'h4F;
      3'd4: s = 7'h66;
      3'd5: s = 7'h6D;
      3'd6: s = 7'h7D;
      3'd7: s = 7'h07;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [6:0] r_seg;

  // Decoded from the next count so the segments change on the same edge as q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= seg_decode(Q_MAX);
    end else begin
      r_seg <= seg_decode(w_q_next);
    end
  end

  assign seg = r_seg;
`endif

  assign q      = r_q;
  assign tick   = w_tick;
  assign borrow = r_borrow;
  assign zero   = (r_q == 3'd0);

endmodule
